// File: rtl/ddr2_fifo_watermark_monitor.sv
// ddr2_fifo_watermark_monitor
//   Multi-channel checker for the DDR2 host-side FIFO flow-control contract
//   (fillcount / notfull / push / pop). Per channel it tracks a high-water
//   region with hysteresis, records peak occupancy, flags contract
//   violations and detects drain stalls. All status outputs are registered
//   (1-cycle latency from the sampled inputs).
//
// Ports
//   clk, reset      clock, synchronous active-high reset (beats clear)
//   fillcount       per-channel occupancy, ch i at [i*CNT_W +: CNT_W]
//   notfull         per-channel space-available flag
//   push, pop       per-channel enqueue / dequeue strobes
//   clear           synchronous clear of statistics and sticky flags
//   high_water      channel is in HIGH
//   viol_flag       sticky per-channel violation flag
//   stall_alarm     sticky per-channel drain-stall flag
//   peak_fill       per-channel maximum fillcount seen
//   viol_count      saturating count of cycles with any violation

// Per-channel checker: hysteresis FSM, violation checks, stall counter, peak.
module ddr2_fifo_wm_chan #(
  parameter int CH_ID         = 0,
  parameter int CNT_W         = 7,
  parameter int DEPTH         = 64,
  parameter int HI_MARK       = 33,
  parameter int LO_MARK       = 30,
  parameter int STALL_LIMIT   = 256,
  parameter int FATAL_ON_VIOL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             prev_valid,
  input  logic [CNT_W-1:0] fill,
  input  logic             notfull,
  input  logic             push,
  input  logic             pop,
  output logic             high_water,
  output logic             viol_flag,
  output logic             stall_alarm,
  output logic [CNT_W-1:0] peak_fill,
  output logic             viol
);
  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] HI_C    = CNT_W'(HI_MARK);
  localparam logic [CNT_W-1:0] LO_C    = CNT_W'(LO_MARK);
  localparam logic [CNT_W-1:0] HI_M1_C = CNT_W'(HI_MARK - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  STL_C   = SC_W'(STALL_LIMIT);

  typedef enum logic {NORMAL = 1'b0, HIGH = 1'b1} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= NORMAL;
    else       state <= state_nxt;
  end

  // Hysteresis: values strictly between the marks keep the current state.
  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (fill >= HI_C) state_nxt = HIGH;
      HIGH:    if (fill <= LO_C) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  assign high_water = (state == HIGH);

  // Accepted strobes and the previous cycle's view, for the conservation check.
  logic             acc_push, acc_pop;
  logic [CNT_W-1:0] prev_fill, exp_fill;
  logic             prev_acc_push, prev_acc_pop;

  assign acc_push = push & notfull;
  assign acc_pop  = pop & (fill != '0);

  always_ff @(posedge clk) begin
    prev_fill     <= fill;
    prev_acc_push <= acc_push;
    prev_acc_pop  <= acc_pop;
  end

  // Wraps mod 2^CNT_W; push+pop together nets to no change.
  assign exp_fill = prev_fill + CNT_W'(prev_acc_push) - CNT_W'(prev_acc_pop);

  // v[0]=V1 overflow attempt, v[1]=V2 underflow, v[2]=V3 over depth,
  // v[3]=V4 fill not conserved, v[4]=V5 spurious back-pressure.
  logic [4:0] v;
  always_comb begin
    v    = '0;
    v[0] = push & ~notfull;
    v[1] = pop & (fill == '0);
    v[2] = fill > DEPTH_C;
    v[3] = prev_valid & (fill != exp_fill);
    v[4] = ~notfull & (fill < HI_M1_C);
  end
  assign viol = |v;

  // Stall counter only runs while staying in HIGH with no pop; anything else
  // (pop, leaving HIGH, being in NORMAL) returns it to zero.
  logic [SC_W-1:0] stall_cnt, cnt_nxt;
  always_comb begin
    cnt_nxt = '0;
    if (state == HIGH && state_nxt == HIGH && !pop)
      cnt_nxt = (stall_cnt == STL_C) ? stall_cnt : stall_cnt + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stall_cnt   <= '0;
      stall_alarm <= 1'b0;
      viol_flag   <= 1'b0;
      peak_fill   <= '0;
    end else begin
      stall_cnt   <= cnt_nxt;
      stall_alarm <= stall_alarm | (cnt_nxt == STL_C);
      viol_flag   <= viol_flag | viol;
      if (fill > peak_fill) peak_fill <= fill;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      if (state_nxt != state)
        $display("%0t wm ch%0d %s fill=%0d", $time, CH_ID,
                 (state_nxt == HIGH) ? "NORMAL->HIGH" : "HIGH->NORMAL", fill);
      if (!clear) begin
        for (int k = 0; k < 5; k++)
          if (v[k])
            $display("%0t wm ch%0d violation V%0d fill=%0d notfull=%b push=%b pop=%b exp=%0d",
                     $time, CH_ID, k + 1, fill, notfull, push, pop, exp_fill);
        if (FATAL_ON_VIOL != 0 && viol)
          $fatal(1, "wm ch%0d violation, stopping", CH_ID);
      end
    end
  end
`endif
endmodule

module ddr2_fifo_watermark_monitor #(
  parameter int NUM_CH        = 2,
  parameter int CNT_W         = 7,
  parameter int DEPTH         = 64,
  parameter int HI_MARK       = 33,
  parameter int LO_MARK       = 30,
  parameter int STALL_LIMIT   = 256,
  parameter int VC_W          = 8,
  parameter int FATAL_ON_VIOL = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*CNT_W-1:0] fillcount,
  input  logic [NUM_CH-1:0]       notfull,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic                    clear,
  output logic [NUM_CH-1:0]       high_water,
  output logic [NUM_CH-1:0]       viol_flag,
  output logic [NUM_CH-1:0]       stall_alarm,
  output logic [NUM_CH*CNT_W-1:0] peak_fill,
  output logic [VC_W-1:0]         viol_count
);
  logic [NUM_CH-1:0][CNT_W-1:0] fill_a, peak_a;
  logic [NUM_CH-1:0]            ch_viol;
  logic                         prev_valid;

  assign fill_a    = fillcount;
  assign peak_fill = peak_a;

  // First cycle after reset has no meaningful history for the conservation check.
  always_ff @(posedge clk) begin
    if (reset) prev_valid <= 1'b0;
    else       prev_valid <= 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ddr2_fifo_wm_chan #(
      .CH_ID(i), .CNT_W(CNT_W), .DEPTH(DEPTH), .HI_MARK(HI_MARK),
      .LO_MARK(LO_MARK), .STALL_LIMIT(STALL_LIMIT), .FATAL_ON_VIOL(FATAL_ON_VIOL)
    ) u_ch (
      .clk(clk), .reset(reset), .clear(clear), .prev_valid(prev_valid),
      .fill(fill_a[i]), .notfull(notfull[i]), .push(push[i]), .pop(pop[i]),
      .high_water(high_water[i]), .viol_flag(viol_flag[i]),
      .stall_alarm(stall_alarm[i]), .peak_fill(peak_a[i]), .viol(ch_viol[i])
    );
  end

  // One count per violating cycle regardless of how many channels/checks fired.
  always_ff @(posedge clk) begin
    if (reset || clear)
      viol_count <= '0;
    else if (|ch_viol && viol_count != {VC_W{1'b1}})
      viol_count <= viol_count + VC_W'(1);
  end
endmodule

// File: tb/tb_ddr2_fifo_watermark_monitor.sv
module tb_ddr2_fifo_watermark_monitor;
  logic        clk = 1'b0;
  logic        reset, clear;
  logic [13:0] fillcount;
  logic [1:0]  notfull, push, pop;
  logic [1:0]  hw, vf, sa;
  logic [13:0] pk;
  logic [7:0]  vc;
  logic [1:0]  hw2, vf2, sa2;
  logic [13:0] pk2;
  logic [1:0]  vc2;

  always #5 clk = ~clk;

  ddr2_fifo_watermark_monitor dut (
    .clk(clk), .reset(reset), .fillcount(fillcount), .notfull(notfull),
    .push(push), .pop(pop), .clear(clear), .high_water(hw), .viol_flag(vf),
    .stall_alarm(sa), .peak_fill(pk), .viol_count(vc));

  ddr2_fifo_watermark_monitor #(.VC_W(2)) dut_s (
    .clk(clk), .reset(reset), .fillcount(fillcount), .notfull(notfull),
    .push(push), .pop(pop), .clear(clear), .high_water(hw2), .viol_flag(vf2),
    .stall_alarm(sa2), .peak_fill(pk2), .viol_count(vc2));

  localparam logic [5:0] M_HW = 6'd1, M_VF = 6'd2, M_SA = 6'd4,
                         M_PK = 6'd8, M_VC = 6'd16, M_VC2 = 6'd32;

  typedef struct packed {
    logic [5:0]  mask;
    logic [1:0]  hw, vf, sa;
    logic [13:0] pk;
    logic [7:0]  vc;
    logic [1:0]  vc2;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  exp_t  pend;
  string pend_nm;
  int    errors = 0, checks = 0;

  // Arm an expectation for the outputs after the next driven cycle.
  task automatic want(input logic [5:0] m, input logic [1:0] ehw, evf, esa,
                      input logic [13:0] epk, input logic [7:0] evc,
                      input logic [1:0] evc2, input string nm);
    pend.mask = m; pend.hw = ehw; pend.vf = evf; pend.sa = esa;
    pend.pk = epk; pend.vc = evc; pend.vc2 = evc2; pend_nm = nm;
  endtask

  task automatic go(input logic r, c, input int f0, f1,
                    input logic [1:0] ps, pp, nf);
    @(negedge clk);
    reset = r; clear = c; fillcount = {7'(f1), 7'(f0)};
    push = ps; pop = pp; notfull = nf;
    @(posedge clk);
    q.push_back(pend); nq.push_back(pend_nm);
    pend.mask = '0;
  endtask

  // Monitor: one expectation per cycle, compared half a cycle after the edge.
  exp_t  e;
  string nm;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front(); nm = nq.pop_front();
      if (e.mask[0]) begin checks++; if (hw !== e.hw) begin errors++;
        $display("FAIL %s high_water got %b want %b", nm, hw, e.hw); end end
      if (e.mask[1]) begin checks++; if (vf !== e.vf) begin errors++;
        $display("FAIL %s viol_flag got %b want %b", nm, vf, e.vf); end end
      if (e.mask[2]) begin checks++; if (sa !== e.sa) begin errors++;
        $display("FAIL %s stall_alarm got %b want %b", nm, sa, e.sa); end end
      if (e.mask[3]) begin checks++; if (pk !== e.pk) begin errors++;
        $display("FAIL %s peak_fill got %h want %h", nm, pk, e.pk); end end
      if (e.mask[4]) begin checks++; if (vc !== e.vc) begin errors++;
        $display("FAIL %s viol_count got %0d want %0d", nm, vc, e.vc); end end
      if (e.mask[5]) begin checks++; if (vc2 !== e.vc2) begin errors++;
        $display("FAIL %s viol_count(VC_W=2) got %0d want %0d", nm, vc2, e.vc2); end end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    pend = '0; pend_nm = "";
    reset = 1'b1; clear = 1'b0; fillcount = '0; push = '0; pop = '0; notfull = 2'b11;
    go(1, 0, 0, 0, 2'b00, 2'b00, 2'b11);
    want(M_HW|M_VF|M_SA|M_PK|M_VC|M_VC2, 0, 0, 0, 0, 0, 0, "reset");
    go(1, 0, 0, 0, 2'b00, 2'b00, 2'b11);

    // ch0 fills 0 -> 40 with push only
    for (int f = 0; f < 40; f++) begin
      if (f == 32) want(M_HW, 2'b00, 0, 0, 0, 0, 0, "below_hi_32");
      if (f == 33) want(M_HW, 2'b01, 0, 0, 0, 0, 0, "enter_hi_33");
      go(0, 0, f, 0, 2'b01, 2'b00, 2'b11);
    end
    want(M_HW|M_VF|M_PK|M_VC, 2'b01, 2'b00, 0, {7'd0, 7'd40}, 0, 0, "fill_40");
    go(0, 0, 40, 0, 2'b00, 2'b00, 2'b11);

    // drain to 31 (still HIGH), then 30 (leaves HIGH), ramp back to 33
    for (int f = 40; f >= 31; f--) begin
      if (f == 31) want(M_HW, 2'b01, 0, 0, 0, 0, 0, "hold_31");
      go(0, 0, f, 0, 2'b00, 2'b01, 2'b11);
    end
    want(M_HW, 2'b00, 0, 0, 0, 0, 0, "exit_30");
    go(0, 0, 30, 0, 2'b00, 2'b00, 2'b11);
    go(0, 0, 30, 0, 2'b01, 2'b00, 2'b11);
    go(0, 0, 31, 0, 2'b01, 2'b00, 2'b11);
    want(M_HW, 2'b00, 0, 0, 0, 0, 0, "ramp_32");
    go(0, 0, 32, 0, 2'b01, 2'b00, 2'b11);
    want(M_HW|M_VC, 2'b01, 0, 0, 0, 0, 0, "reenter_33");
    go(0, 0, 33, 0, 2'b00, 2'b00, 2'b11);
    for (int f = 33; f >= 31; f--) go(0, 0, f, 0, 2'b00, 2'b01, 2'b11);
    go(0, 0, 30, 0, 2'b00, 2'b00, 2'b11);

    // ch1: overflow attempt at 64, later underflow at 0
    for (int f = 0; f < 64; f++) go(0, 0, 30, f, 2'b10, 2'b00, 2'b11);
    want(M_VF|M_VC, 0, 2'b10, 0, 0, 8'd1, 0, "v1_ch1");
    go(0, 0, 30, 64, 2'b10, 2'b00, 2'b01);
    for (int f = 64; f >= 1; f--) go(0, 0, 30, f, 2'b00, 2'b10, 2'b11);
    want(M_VF|M_VC, 0, 2'b10, 0, 0, 8'd2, 0, "v2_ch1");
    go(0, 0, 30, 0, 2'b00, 2'b10, 2'b11);

    // ch0 conservation: accepted push at 10, then 12 appears
    for (int f = 30; f >= 11; f--) go(0, 0, f, 0, 2'b00, 2'b01, 2'b11);
    go(0, 0, 10, 0, 2'b01, 2'b00, 2'b11);
    want(M_VF|M_VC, 0, 2'b11, 0, 0, 8'd3, 0, "v4_ch0");
    go(0, 0, 12, 0, 2'b00, 2'b00, 2'b11);
    want(M_VC, 0, 0, 0, 0, 8'd3, 0, "pushpop_edge");
    go(0, 0, 12, 0, 2'b01, 2'b01, 2'b11);
    want(M_VC, 0, 0, 0, 0, 8'd3, 0, "pushpop_nochg");
    go(0, 0, 12, 0, 2'b00, 2'b00, 2'b11);

    // drain stall: hold at 50 without pop
    for (int f = 12; f < 50; f++) go(0, 0, f, 0, 2'b01, 2'b00, 2'b11);
    go(0, 0, 50, 0, 2'b01, 2'b01, 2'b11);
    for (int k = 1; k <= 256; k++) begin
      if (k == 255) want(M_SA, 0, 0, 2'b00, 0, 0, 0, "stall_255");
      if (k == 256) want(M_SA|M_HW, 2'b01, 0, 2'b01, 0, 0, 0, "stall_256");
      go(0, 0, 50, 0, 2'b00, 2'b00, 2'b11);
    end

    // clear keeps high_water, then a pop at cycle 200 restarts the stall count
    want(M_HW|M_VF|M_SA|M_PK|M_VC, 2'b01, 0, 0, 0, 0, 0, "clear_1");
    go(0, 1, 50, 0, 2'b01, 2'b01, 2'b11);
    for (int k = 1; k <= 199; k++) begin
      if (k == 1) want(M_PK, 0, 0, 0, {7'd0, 7'd50}, 0, 0, "peak_after_clear");
      go(0, 0, 50, 0, 2'b00, 2'b00, 2'b11);
    end
    go(0, 0, 50, 0, 2'b01, 2'b01, 2'b11);
    for (int k = 1; k <= 56; k++) begin
      if (k == 56) want(M_SA, 0, 0, 2'b00, 0, 0, 0, "no_stall_256");
      go(0, 0, 50, 0, 2'b00, 2'b00, 2'b11);
    end

    // five violating cycles: 8-bit counter reaches 5, 2-bit counter sticks at 3
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) want(M_VC|M_VC2, 0, 0, 0, 0, 8'd2, 2'd2, "sat_2");
      if (k == 3) want(M_VC|M_VC2, 0, 0, 0, 0, 8'd3, 2'd3, "sat_3");
      if (k == 5) want(M_VF|M_VC|M_VC2, 0, 2'b10, 0, 0, 8'd5, 2'd3, "sat_5");
      go(0, 0, 50, 0, 2'b00, 2'b10, 2'b11);
    end
    want(M_HW|M_VF|M_SA|M_PK|M_VC|M_VC2, 2'b01, 0, 0, 0, 0, 0, "clear_2");
    go(0, 1, 50, 0, 2'b00, 2'b00, 2'b11);

    // spurious back-pressure, then over-depth (with broken conservation) in one cycle
    want(M_VF|M_VC, 0, 2'b10, 0, 0, 8'd1, 0, "v5_ch1");
    go(0, 0, 50, 0, 2'b00, 2'b00, 2'b01);
    want(M_VF|M_VC, 0, 2'b10, 0, 0, 8'd2, 0, "v3_ch1");
    go(0, 0, 50, 65, 2'b00, 2'b00, 2'b11);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
